// File: rtl/rgmii_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_tx_ctrl
// Brief    : Byte-stream to RGMII SDR-nibble framer: preamble/SFD, pad, FCS, IFG
// Revision : 1.0 - initial release
// ============================================================================
module rgmii_tx_ctrl #(
    parameter int MIN_FRAME  = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic       phy_clk,
    input  logic       phy_rst_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [3:0] txd_d1,
    output logic [3:0] txd_d2,
    output logic       tx_ctl_d1,
    output logic       tx_ctl_d2,
    output logic       tx_busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_DROP, ST_IFG
    } state_t;

    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] PRE_LAST = 16'd6;
    localparam logic [15:0] FCS_LAST = 16'd3;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] count_q, count_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        ctl1_q, ctl1_d;
    logic        ctl2_q, ctl2_d;
    logic        busy_q;
    logic        underflow_q, underflow_d;
    logic [15:0] count_inc;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    assign fcs_word  = ~crc_q;
    assign s_tready  = (state_q == ST_DATA) || (state_q == ST_DROP);

    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (timer_q[1:0])
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            2'd3:    fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // Timer restarts from zero on every state change; states that dwell bump it.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        count_d     = count_q;
        crc_d       = crc_q;
        txd_d       = 8'h00;
        ctl1_d      = 1'b0;
        ctl2_d      = 1'b0;
        underflow_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                crc_d   = 32'hFFFF_FFFF;
                if (s_tvalid) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                txd_d  = 8'h55;
                ctl1_d = 1'b1;
                ctl2_d = 1'b1;
                if (timer_q == PRE_LAST) state_d = ST_SFD;
                else                     timer_d = timer_q + 16'd1;
            end
            ST_SFD: begin
                txd_d   = 8'hD5;
                ctl1_d  = 1'b1;
                ctl2_d  = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (s_tvalid) begin
                    txd_d   = s_tdata;
                    ctl1_d  = 1'b1;
                    ctl2_d  = 1'b1;
                    crc_d   = crc32_byte(crc_q, s_tdata);
                    count_d = count_inc;
                    if (s_tlast) state_d = (count_inc < MIN_LEN) ? ST_PAD : ST_FCS;
                end else begin
                    // TX_ER with TX_EN: ctl_d2 = EN xor ER drops low
                    ctl1_d      = 1'b1;
                    underflow_d = 1'b1;
                    state_d     = ST_DROP;
                end
            end
            ST_PAD: begin
                ctl1_d  = 1'b1;
                ctl2_d  = 1'b1;
                crc_d   = crc32_byte(crc_q, 8'h00);
                count_d = count_inc;
                if (count_inc >= MIN_LEN) state_d = ST_FCS;
            end
            ST_FCS: begin
                txd_d  = fcs_byte;
                ctl1_d = 1'b1;
                ctl2_d = 1'b1;
                if (timer_q == FCS_LAST) state_d = ST_IFG;
                else                     timer_d = timer_q + 16'd1;
            end
            ST_DROP: begin
                if (s_tvalid && s_tlast) state_d = ST_IFG;
            end
            ST_IFG: begin
                if (timer_q == IFG_LAST) state_d = ST_IDLE;
                else                     timer_d = timer_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge phy_clk or negedge phy_rst_n) begin
        if (!phy_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            crc_q       <= 32'hFFFF_FFFF;
            txd_q       <= '0;
            ctl1_q      <= 1'b0;
            ctl2_q      <= 1'b0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            ctl1_q      <= ctl1_d;
            ctl2_q      <= ctl2_d;
            busy_q      <= (state_d != ST_IDLE);
            underflow_q <= underflow_d;
        end
    end

    assign txd_d1    = txd_q[3:0];
    assign txd_d2    = txd_q[7:4];
    assign tx_ctl_d1 = ctl1_q;
    assign tx_ctl_d2 = ctl2_q;
    assign tx_busy   = busy_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
